// File: rtl/router_input_queue_if.sv
// -----------------------------------------------------------------------------
// router_input_queue_if
//   AXI-Stream flit channel used between NoC router stages.
//   master: drives tvalid and the flit payload, samples tready.
//   slave : samples tvalid and the flit payload, drives tready.
//   Signals: tvalid, tdata[DATA_WIDTH], tid[ID_WIDTH], tdest[DEST_WIDTH],
//            tuser[USER_WIDTH], tlast, tready.
// -----------------------------------------------------------------------------
interface router_input_queue_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DEST_WIDTH = 4,
  parameter int USER_WIDTH = 4
);
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic [ID_WIDTH-1:0]   tid;
  logic [DEST_WIDTH-1:0] tdest;
  logic [USER_WIDTH-1:0] tuser;
  logic                  tlast;
  logic                  tready;

  modport master (
    output tvalid, tdata, tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tid, tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/router_input_queue.sv
// -----------------------------------------------------------------------------
// router_input_queue
//   Per-port ingress stage of the AXI-Stream NoC router. Buffers incoming
//   flits in a small FIFO, decodes the routing-header flit into target X/Y
//   coordinates that stay fixed until the packet's TLAST flit leaves, and
//   drops body flits that arrive without a preceding header.
//
// Ports:
//   clk_i         clock
//   rst_i         synchronous, active-high reset
//   in_if         upstream flit channel (slave)
//   out_if        flit channel to the routing stage (master)
//   target_x_o    destination X of the current packet
//   target_y_o    destination Y of the current packet
//   stray_flit_o  one-cycle pulse per dropped headerless flit
//
// Optional build macro ROUTER_INPUT_QUEUE_STATS_EN adds:
//   occupancy_o   current number of buffered flits
//   pkt_count_o   16-bit wrapping count of forwarded TLAST flits
// -----------------------------------------------------------------------------
module router_input_queue #(
  parameter int DATA_WIDTH    = 32,
  parameter int ID_WIDTH      = 4,
  parameter int DEST_WIDTH    = 4,
  parameter int USER_WIDTH    = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_ROUTERS_X = 4,
  parameter int MAX_ROUTERS_Y = 4,
  parameter logic [ID_WIDTH-1:0] ROUTING_HEADER = '1,
  localparam int MAX_ROUTERS_X_WIDTH = $clog2(MAX_ROUTERS_X),
  localparam int MAX_ROUTERS_Y_WIDTH = $clog2(MAX_ROUTERS_Y),
  localparam int PTR_W = $clog2(FIFO_DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  router_input_queue_if.slave            in_if,
  router_input_queue_if.master           out_if,
  output logic [MAX_ROUTERS_X_WIDTH-1:0] target_x_o,
  output logic [MAX_ROUTERS_Y_WIDTH-1:0] target_y_o,
  output logic                           stray_flit_o
`ifdef ROUTER_INPUT_QUEUE_STATS_EN
  ,
  output logic [CNT_W-1:0]               occupancy_o,
  output logic [15:0]                    pkt_count_o
`endif
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic [ID_WIDTH-1:0]   tid;
    logic [DEST_WIDTH-1:0] tdest;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
  } flit_t;

  typedef enum logic {
    S_HEAD = 1'b0,
    S_BODY = 1'b1
  } state_t;

  // Header coordinate extraction: X in the low bits, Y directly above it.
  function automatic logic [MAX_ROUTERS_X_WIDTH-1:0] decode_x(
    input logic [DATA_WIDTH-1:0] d
  );
    return d[MAX_ROUTERS_X_WIDTH-1:0];
  endfunction

  function automatic logic [MAX_ROUTERS_Y_WIDTH-1:0] decode_y(
    input logic [DATA_WIDTH-1:0] d
  );
    return d[MAX_ROUTERS_X_WIDTH +: MAX_ROUTERS_Y_WIDTH];
  endfunction

  flit_t                          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]               wr_ptr;
  logic [PTR_W-1:0]               rd_ptr;
  logic [CNT_W-1:0]               count;
  state_t                         state;
  logic [MAX_ROUTERS_X_WIDTH-1:0] tgt_x_q;
  logic [MAX_ROUTERS_Y_WIDTH-1:0] tgt_y_q;
  logic                           stray_p1;

  flit_t                          in_flit;
  flit_t                          head_p0;
  logic                           head_hdr;
  logic                           empty;
  logic                           in_rdy;
  logic                           push;
  logic                           pop;
  logic                           drop;
  logic                           vld_p0;
  logic [MAX_ROUTERS_X_WIDTH-1:0] tgt_x;
  logic [MAX_ROUTERS_Y_WIDTH-1:0] tgt_y;

  // ---- ingress: write side of the FIFO ----
  assign in_flit = '{tdata: in_if.tdata, tid: in_if.tid, tdest: in_if.tdest,
                     tuser: in_if.tuser, tlast: in_if.tlast};

  // Ready looks only at the registered count, so a pop while full never
  // opens a same-cycle push slot.
  assign in_rdy      = (count != CNT_W'(FIFO_DEPTH));
  assign in_if.tready = in_rdy;
  assign push        = in_if.tvalid && in_rdy;

  // Payload storage carries no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= in_flit;
    end
  end

  // ---- stage p0: head of queue, header decode and pop decision ----
  assign head_p0  = mem[rd_ptr];
  assign empty    = (count == '0);
  assign head_hdr = (head_p0.tid == ROUTING_HEADER);

  always_comb begin
    vld_p0 = 1'b0;
    pop    = 1'b0;
    drop   = 1'b0;
    tgt_x  = tgt_x_q;
    tgt_y  = tgt_y_q;
    unique case (state)
      S_HEAD: begin
        if (!empty) begin
          if (head_hdr) begin
            // Targets bypass the registers so the routing stage can pick a
            // port in the same cycle the header is offered.
            vld_p0 = 1'b1;
            tgt_x  = decode_x(head_p0.tdata);
            tgt_y  = decode_y(head_p0.tdata);
            pop    = out_if.tready;
          end else begin
            // Headerless flit: discard without offering it downstream.
            drop = 1'b1;
            pop  = 1'b1;
          end
        end
      end
      S_BODY: begin
        vld_p0 = !empty;
        pop    = vld_p0 && out_if.tready;
      end
      default: begin
        vld_p0 = 1'b0;
      end
    endcase
  end

  assign out_if.tvalid = vld_p0;
  assign out_if.tdata  = head_p0.tdata;
  assign out_if.tid    = head_p0.tid;
  assign out_if.tdest  = head_p0.tdest;
  assign out_if.tuser  = head_p0.tuser;
  assign out_if.tlast  = head_p0.tlast;

  assign target_x_o = tgt_x;
  assign target_y_o = tgt_y;

  // ---- stage p1: pointer/count/FSM update and registered drop pulse ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= S_HEAD;
      tgt_x_q  <= '0;
      tgt_y_q  <= '0;
      stray_p1 <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      stray_p1 <= drop;

      if (pop && !drop) begin
        unique case (state)
          S_HEAD: begin
            tgt_x_q <= decode_x(head_p0.tdata);
            tgt_y_q <= decode_y(head_p0.tdata);
            if (!head_p0.tlast) begin
              state <= S_BODY;
            end
          end
          S_BODY: begin
            if (head_p0.tlast) begin
              state <= S_HEAD;
            end
          end
          default: state <= S_HEAD;
        endcase
      end
    end
  end

  assign stray_flit_o = stray_p1;

`ifdef ROUTER_INPUT_QUEUE_STATS_EN
  logic [15:0] pkt_cnt_q;

  // Only forwarded packet ends count; dropped strays never reach here.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pkt_cnt_q <= '0;
    end else if (pop && !drop && head_p0.tlast) begin
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign occupancy_o = count;
  assign pkt_count_o = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_router_input_queue.sv
// -----------------------------------------------------------------------------
// tb_router_input_queue
//   Table of per-cycle vectors {inputs, expected outputs} plus a streaming
//   sequence that pushes three 5-flit packets through the 4-entry queue.
// -----------------------------------------------------------------------------
module tb_router_input_queue;

  localparam logic [3:0] H = 4'hF;  // ROUTING_HEADER
  localparam logic [3:0] B = 4'h0;  // ordinary body TID

  logic clk = 1'b0;
  logic rst_i;
  logic [1:0] target_x;
  logic [1:0] target_y;
  logic       stray;
`ifdef ROUTER_INPUT_QUEUE_STATS_EN
  logic [2:0]  occupancy;
  logic [15:0] pkt_count;
`endif

  always #5 clk = ~clk;

  router_input_queue_if in_bus ();
  router_input_queue_if out_bus ();

  router_input_queue dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .in_if        (in_bus),
    .out_if       (out_bus),
    .target_x_o   (target_x),
    .target_y_o   (target_y),
    .stray_flit_o (stray)
`ifdef ROUTER_INPUT_QUEUE_STATS_EN
    ,
    .occupancy_o  (occupancy),
    .pkt_count_o  (pkt_count)
`endif
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] id;
    logic [3:0]  itid;
    logic        il;
    logic        ordy;
    logic        irdy;
    logic        ov;
    logic [31:0] od;
    logic        ol;
    logic [1:0]  tx;
    logic [1:0]  ty;
    logic        st;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tid;
    logic        last;
    logic [3:0]  dest;
    logic [1:0]  tx;
    logic [1:0]  ty;
  } flit_exp_t;

  vec_t      vecs[$];
  flit_exp_t stream[$];
  int        n_checks = 0;
  int        n_fail   = 0;

  function automatic vec_t v(logic rst, logic iv, logic [31:0] id, logic [3:0] itid,
                             logic il, logic ordy, logic irdy, logic ov,
                             logic [31:0] od, logic ol, logic [1:0] tx,
                             logic [1:0] ty, logic st);
    vec_t r;
    r.rst = rst; r.iv = iv; r.id = id; r.itid = itid; r.il = il; r.ordy = ordy;
    r.irdy = irdy; r.ov = ov; r.od = od; r.ol = ol; r.tx = tx; r.ty = ty; r.st = st;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] d, input logic [3:0] tid,
                       input logic last, input logic [3:0] dest, input logic ordy);
    in_bus.tvalid  = iv;
    in_bus.tdata   = d;
    in_bus.tid     = tid;
    in_bus.tdest   = dest;
    in_bus.tuser   = ~dest;
    in_bus.tlast   = last;
    out_bus.tready = ordy;
  endtask

  initial begin
    int rcv;
    int sent;
    logic acc;

    // Single packet to (1,2): header 0x9, two bodies.
    vecs.push_back(v(0,1,'h9 ,H,0,1, 1,0,'h0 ,0, 0,0,0));
    vecs.push_back(v(0,1,'hA1,B,0,1, 1,1,'h9 ,0, 1,2,0));
    vecs.push_back(v(0,1,'hA2,B,1,1, 1,1,'hA1,0, 1,2,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,1,'hA2,1, 1,2,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,0,'h0 ,0, 1,2,0));
    // Backpressure fill: packet to (2,1), five flits with out TREADY low.
    vecs.push_back(v(0,1,'h6 ,H,0,0, 1,0,'h0 ,0, 1,2,0));
    vecs.push_back(v(0,1,'hB1,B,0,0, 1,1,'h6 ,0, 2,1,0));
    vecs.push_back(v(0,1,'hB2,B,0,0, 1,1,'h6 ,0, 2,1,0));
    vecs.push_back(v(0,1,'hB3,B,0,0, 1,1,'h6 ,0, 2,1,0));
    vecs.push_back(v(0,1,'hB4,B,1,0, 0,1,'h6 ,0, 2,1,0));
    vecs.push_back(v(0,1,'hB4,B,1,1, 0,1,'h6 ,0, 2,1,0));
    vecs.push_back(v(0,1,'hB4,B,1,1, 1,1,'hB1,0, 2,1,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,1,'hB2,0, 2,1,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,1,'hB3,0, 2,1,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,1,'hB4,1, 2,1,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,0,'h0 ,0, 2,1,0));
    // Reset, then stray body flit followed by single-flit header to (1,3).
    vecs.push_back(v(1,0,'h0 ,B,0,1, 1,0,'h0 ,0, 2,1,0));
    vecs.push_back(v(0,1,'h55,B,0,1, 1,0,'h0 ,0, 0,0,0));
    vecs.push_back(v(0,1,'hD ,H,1,1, 1,0,'h0 ,0, 0,0,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,1,'hD ,1, 1,3,1));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,0,'h0 ,0, 1,3,0));
    // Back-to-back single-flit packets to (3,0) and (0,3).
    vecs.push_back(v(0,1,'h3 ,H,1,1, 1,0,'h0 ,0, 1,3,0));
    vecs.push_back(v(0,1,'hC ,H,1,1, 1,1,'h3 ,1, 3,0,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,1,'hC ,1, 0,3,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,0,'h0 ,0, 0,3,0));
    // Reset mid-packet after header (2,2) + one body; next body is stray.
    vecs.push_back(v(0,1,'hA ,H,0,1, 1,0,'h0 ,0, 0,3,0));
    vecs.push_back(v(0,1,'hE1,B,0,0, 1,1,'hA ,0, 2,2,0));
    vecs.push_back(v(1,0,'h0 ,B,0,0, 1,1,'hA ,0, 2,2,0));
    vecs.push_back(v(0,1,'hE2,B,1,1, 1,0,'h0 ,0, 0,0,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,0,'h0 ,0, 0,0,0));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,0,'h0 ,0, 0,0,1));
    vecs.push_back(v(0,0,'h0 ,B,0,1, 1,0,'h0 ,0, 0,0,0));

    // Three 5-flit packets to (1,3), (2,2), (3,1).
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 5; k++) begin
        flit_exp_t f;
        f.tx   = 2'(p + 1);
        f.ty   = 2'(3 - p);
        f.data = (k == 0) ? {28'd0, f.ty, f.tx} : 32'h1000 * (p + 1) + k;
        f.tid  = (k == 0) ? H : B;
        f.last = (k == 4);
        f.dest = 4'(p * 5 + k);
        stream.push_back(f);
      end
    end

    rst_i = 1'b1;
    drive(0, '0, B, 0, '0, 1);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_i = vecs[i].rst;
      drive(vecs[i].iv, vecs[i].id, vecs[i].itid, vecs[i].il, 4'h0, vecs[i].ordy);
      #1;
      check($sformatf("v%0d.in_tready", i), 32'(in_bus.tready), 32'(vecs[i].irdy));
      check($sformatf("v%0d.out_tvalid", i), 32'(out_bus.tvalid), 32'(vecs[i].ov));
      if (vecs[i].ov) begin
        check($sformatf("v%0d.out_tdata", i), out_bus.tdata, vecs[i].od);
        check($sformatf("v%0d.out_tlast", i), 32'(out_bus.tlast), 32'(vecs[i].ol));
      end
      check($sformatf("v%0d.target_x", i), 32'(target_x), 32'(vecs[i].tx));
      check($sformatf("v%0d.target_y", i), 32'(target_y), 32'(vecs[i].ty));
      check($sformatf("v%0d.stray", i), 32'(stray), 32'(vecs[i].st));
`ifdef ROUTER_INPUT_QUEUE_STATS_EN
      if (i == 0) check("v0.occupancy", 32'(occupancy), 32'd0);
`endif
    end

    // Continuous push/pop across the pointer wrap, bounded cycle budget.
    rcv  = 0;
    sent = 0;
    for (int cyc = 0; cyc < 60 && rcv < stream.size(); cyc++) begin
      @(negedge clk);
      rst_i = 1'b0;
      if (sent < stream.size())
        drive(1, stream[sent].data, stream[sent].tid, stream[sent].last,
              stream[sent].dest, 1);
      else
        drive(0, '0, B, 0, '0, 1);
      #1;
      acc = in_bus.tvalid && in_bus.tready;
      if (out_bus.tvalid) begin
        if (rcv < stream.size()) begin
          check($sformatf("s%0d.tdata", rcv), out_bus.tdata, stream[rcv].data);
          check($sformatf("s%0d.tid", rcv), 32'(out_bus.tid), 32'(stream[rcv].tid));
          check($sformatf("s%0d.tlast", rcv), 32'(out_bus.tlast), 32'(stream[rcv].last));
          check($sformatf("s%0d.tdest", rcv), 32'(out_bus.tdest), 32'(stream[rcv].dest));
          check($sformatf("s%0d.target_x", rcv), 32'(target_x), 32'(stream[rcv].tx));
          check($sformatf("s%0d.target_y", rcv), 32'(target_y), 32'(stream[rcv].ty));
        end
        rcv++;
      end
      if (acc) sent++;
    end
    check("stream.flits_received", 32'(rcv), 32'(stream.size()));

    @(negedge clk);
    drive(0, '0, B, 0, '0, 1);
    #1;
    check("stream.stray", 32'(stray), 32'd0);
    check("stream.drained_tvalid", 32'(out_bus.tvalid), 32'd0);
`ifdef ROUTER_INPUT_QUEUE_STATS_EN
    check("stats.pkt_count", 32'(pkt_count), 32'd3);
    check("stats.occupancy", 32'(occupancy), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
